// File: rtl/jof32_hazard_ctrl.sv
// JOF32 pipeline sequencing: load-use bubble, taken-branch flush, data-memory freeze
// with timeout abort, plus a saturating stall-cycle counter.
module jof32_hazard_ctrl #(
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned BR_FLUSH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_dir_wb,
    input  logic              ex_sel_ld,
    input  logic              ex_reg_wr,
    input  logic              br_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_flush,
    output logic              fault,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  fcnt, fcnt_nxt;
    logic [7:0]  wcnt, wcnt_nxt;
    logic        fault_set;
    logic        mem_stall;
    logic        ld_use;
    logic        timeout;

    assign mem_stall = mem_req & ~mem_ack;
    assign ld_use    = ex_sel_ld & ex_reg_wr &
                       ((id_use_rs1 & (id_rs1 == ex_dir_wb)) |
                        (id_use_rs2 & (id_rs2 == ex_dir_wb)));
    assign timeout   = (wcnt >= 8'(MEM_TIMEOUT));

    // State register and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            fcnt      <= '0;
            wcnt      <= '0;
            fault     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            wcnt  <= wcnt_nxt;
            if (fault_set)
                fault <= 1'b1;
            if (!pc_en && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Next state: memory wait outranks branch; load-use needs no state
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        wcnt_nxt  = wcnt;
        fault_set = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt = MEMWAIT;
                    wcnt_nxt  = 8'd1;
                end else if (br_taken && BR_FLUSH > 1) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = 2'(BR_FLUSH - 1);
                end
            end
            FLUSH: begin
                if (mem_stall) begin
                    state_nxt = MEMWAIT;
                    wcnt_nxt  = 8'd1;
                    fcnt_nxt  = '0;
                end else begin
                    fcnt_nxt = fcnt - 2'd1;
                    if (fcnt <= 2'd1)
                        state_nxt = RUN;
                end
            end
            MEMWAIT: begin
                if (mem_ack) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end else if (timeout) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                    fault_set = 1'b1;
                end else begin
                    wcnt_nxt = wcnt + 8'd1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Pipeline controls; all forced low while reset is held
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b0;
        if (rst_n) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            case (state)
                RUN, FLUSH: begin
                    if (mem_stall) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                    end else if (state == FLUSH) begin
                        ifid_flush = 1'b1;
                    end else if (br_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (ld_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MEMWAIT: begin
                    if (!mem_ack) begin
                        if (timeout) begin
                            memwb_flush = 1'b1;
                        end else begin
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_en     = 1'b0;
                            exmem_en    = 1'b0;
                            memwb_flush = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jof32_hazard_ctrl.sv
// Directed bench for jof32_hazard_ctrl: hand-computed control vectors per cycle.
module tb_jof32_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs1, id_rs2, ex_dir_wb;
    logic        id_use_rs1, id_use_rs2, ex_sel_ld, ex_reg_wr;
    logic        br_taken, mem_req, mem_ack;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic        fault;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
    localparam logic [6:0] V_OFF   = 7'b0000000;
    localparam logic [6:0] V_DEF   = 7'b1101010;
    localparam logic [6:0] V_HAZ   = 7'b0001110;
    localparam logic [6:0] V_BR    = 7'b1111110;
    localparam logic [6:0] V_FL    = 7'b1111010;
    localparam logic [6:0] V_FRZ   = 7'b0000001;
    localparam logic [6:0] V_ABORT = 7'b1101011;

    jof32_hazard_ctrl #(.REG_AW(4), .MEM_TIMEOUT(15), .BR_FLUSH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_dir_wb(ex_dir_wb), .ex_sel_ld(ex_sel_ld), .ex_reg_wr(ex_reg_wr),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
        .fault(fault), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {9'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush},
            {9'd0, exp});
    endtask

    // Advance to the next negedge, then settle inputs applied by the caller
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_dir_wb = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_sel_ld = 0; ex_reg_wr = 0;
        br_taken = 0; mem_req = 0; mem_ack = 0;
        #2;
        chk_ctl("reset_ctl", V_OFF);
        chk("reset_stall", stall_cnt, 16'd0);
        chk("reset_fault", {15'd0, fault}, 16'd0);

        nxt(); rst_n = 1'b1; #1;
        chk_ctl("run_default", V_DEF);

        // Load-use on rs1
        nxt(); ex_sel_ld = 1; ex_reg_wr = 1; ex_dir_wb = 4'd3; id_rs1 = 4'd3; id_use_rs1 = 1; #1;
        chk_ctl("ldu_rs1", V_HAZ);
        nxt(); ex_sel_ld = 0; #1;
        chk_ctl("ldu_clear", V_DEF);
        chk("ldu_stall1", stall_cnt, 16'd1);

        // Load-use on rs2
        nxt(); ex_sel_ld = 1; id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 4'd3; id_rs1 = 4'd5; #1;
        chk_ctl("ldu_rs2", V_HAZ);
        // Register 0 still counts
        nxt(); ex_dir_wb = 4'd0; id_rs2 = 4'd0; #1;
        chk_ctl("ldu_r0", V_HAZ);
        nxt(); ex_sel_ld = 0; #1;
        chk("ldu_stall3", stall_cnt, 16'd3);

        // No hazard: use bit clear, then reg_wr clear
        nxt(); ex_sel_ld = 1; ex_dir_wb = 4'd3; id_rs1 = 4'd3; id_use_rs1 = 0; id_use_rs2 = 0; #1;
        chk_ctl("nouse", V_DEF);
        nxt(); id_use_rs1 = 1; ex_reg_wr = 0; #1;
        chk_ctl("nowr", V_DEF);
        nxt(); ex_sel_ld = 0; id_use_rs1 = 0; #1;
        chk("nohaz_stall", stall_cnt, 16'd3);

        // Branch with two-cycle front-end flush
        nxt(); br_taken = 1; #1;
        chk_ctl("br_c0", V_BR);
        nxt(); br_taken = 0; #1;
        chk_ctl("br_c1", V_FL);
        nxt(); #1;
        chk_ctl("br_c2", V_DEF);

        // Memory wait arising during FLUSH takes over
        nxt(); br_taken = 1; #1;
        chk_ctl("br2_c0", V_BR);
        nxt(); br_taken = 0; mem_req = 1; #1;
        chk_ctl("flush_memwait", V_FRZ);
        nxt(); mem_ack = 1; #1;
        chk_ctl("flush_mem_ack", V_DEF);
        nxt(); mem_req = 0; mem_ack = 0; #1;
        chk_ctl("flush_after", V_DEF);
        chk("flush_stall", stall_cnt, 16'd4);

        // Three-cycle memory wait, ack on the fourth
        nxt(); mem_req = 1; #1;
        chk_ctl("mw_c0", V_FRZ);
        nxt(); #1;
        chk_ctl("mw_c1", V_FRZ);
        nxt(); #1;
        chk_ctl("mw_c2", V_FRZ);
        nxt(); mem_ack = 1; #1;
        chk_ctl("mw_ack", V_DEF);
        nxt(); mem_req = 0; mem_ack = 0; #1;
        chk_ctl("mw_after", V_DEF);
        chk("mw_stall", stall_cnt, 16'd7);

        // Timeout: 15 frozen cycles, abort cycle, then sticky fault
        nxt(); mem_req = 1; #1;
        for (int i = 0; i < 15; i++) begin
            chk_ctl($sformatf("to_frz%0d", i), V_FRZ);
            nxt(); #1;
        end
        chk_ctl("to_abort", V_ABORT);
        chk("to_fault_pre", {15'd0, fault}, 16'd0);
        nxt(); mem_req = 0; #1;
        chk_ctl("to_after", V_DEF);
        chk("to_fault", {15'd0, fault}, 16'd1);
        chk("to_stall", stall_cnt, 16'd22);
        nxt(); nxt(); #1;
        chk("fault_sticky", {15'd0, fault}, 16'd1);

        // All three events at once: freeze wins
        nxt(); br_taken = 1; mem_req = 1; ex_sel_ld = 1; ex_reg_wr = 1; id_use_rs1 = 1; #1;
        chk_ctl("all_c0", V_FRZ);
        nxt(); #1;
        chk_ctl("all_c1", V_FRZ);
        chk("all_stall", stall_cnt, 16'd23);

        // Asynchronous reset mid-wait
        #2; rst_n = 1'b0; #1;
        chk_ctl("rst_mid_ctl", V_OFF);
        chk("rst_mid_stall", stall_cnt, 16'd0);
        chk("rst_mid_fault", {15'd0, fault}, 16'd0);
        nxt(); br_taken = 0; mem_req = 0; ex_sel_ld = 0; rst_n = 1'b1; #1;
        chk_ctl("rst_release", V_DEF);
        nxt(); #1;
        chk_ctl("rst_run", V_DEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
